// File: rtl/fifo_mac_drain.sv
// Drains operand pairs from two FIFOs in lockstep and multiply-accumulates them.
// The sum is presented on a valid/ready port; overflow is sticky for the current job.
module fifo_mac_drain #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    output logic                  a_rden_o,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  a_empty_i,
    output logic                  b_rden_o,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic                  b_empty_i,
    output logic [ACC_WIDTH-1:0]  result_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic                  busy_o,
    output logic                  overflow_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q;
    logic [CNT_WIDTH-1:0]    len_q;
    logic [CNT_WIDTH-1:0]    issued_q;
    logic [CNT_WIDTH-1:0]    consumed_q;
    logic [CNT_WIDTH-1:0]    consumed_d;
    logic [ACC_WIDTH-1:0]    acc_q;
    logic [ACC_WIDTH-1:0]    result_q;
    logic                    overflow_q;
    logic                    pop_d1_q;
    logic                    pop;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH:0]      sum_d;

    always_comb begin
        pop        = (state_q == StRun) && !a_empty_i && !b_empty_i && (issued_q < len_q);
        prod       = (2*DATA_WIDTH)'(a_data_i) * (2*DATA_WIDTH)'(b_data_i);
        // Extra top bit captures the carry out of the accumulator.
        sum_d      = {1'b0, acc_q} + (ACC_WIDTH+1)'(prod);
        consumed_d = consumed_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            len_q      <= '0;
            issued_q   <= '0;
            consumed_q <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            pop_d1_q   <= 1'b0;
        end else begin
            pop_d1_q <= pop;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        len_q      <= len_i;
                        issued_q   <= '0;
                        consumed_q <= '0;
                        acc_q      <= '0;
                        overflow_q <= 1'b0;
                        if (len_i != '0) begin
                            state_q <= StRun;
                        end else begin
                            result_q <= '0;
                            state_q  <= StDone;
                        end
                    end
                end
                StRun: begin
                    if (pop) begin
                        issued_q <= issued_q + 1'b1;
                    end
                    // FIFO data is valid the cycle after the pop.
                    if (pop_d1_q) begin
                        acc_q      <= sum_d[ACC_WIDTH-1:0];
                        overflow_q <= overflow_q | sum_d[ACC_WIDTH];
                        consumed_q <= consumed_d;
                        if (consumed_d == len_q) begin
                            result_q <= sum_d[ACC_WIDTH-1:0];
                            state_q  <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (result_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign a_rden_o       = pop;
    assign b_rden_o       = pop;
    assign result_o       = result_q;
    assign result_valid_o = (state_q == StDone);
    assign busy_o         = (state_q != StIdle);
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_fifo_mac_drain.sv
// Directed bench for fifo_mac_drain: behavioural FIFOs feed the DUT, each task checks one scenario.
module tb_fifo_mac_drain;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        a_rden;
    logic [15:0] a_data;
    logic        a_empty;
    logic        b_rden;
    logic [15:0] b_data;
    logic        b_empty;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;
    logic        overflow;

    int tests;
    int fails;
    int mon_err;
    int a_pops;
    int b_pops;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    fifo_mac_drain #(
        .DATA_WIDTH(16),
        .ACC_WIDTH (32),
        .CNT_WIDTH (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .len_i         (len),
        .a_rden_o      (a_rden),
        .a_data_i      (a_data),
        .a_empty_i     (a_empty),
        .b_rden_o      (b_rden),
        .b_data_i      (b_data),
        .b_empty_i     (b_empty),
        .result_o      (result),
        .result_valid_o(result_valid),
        .result_ready_i(result_ready),
        .busy_o        (busy),
        .overflow_o    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFOs: pop on rden, data valid the following cycle.
    always @(posedge clk) begin
        if (a_rden !== b_rden) mon_err++;
        if (a_rden === 1'b1) begin
            a_pops++;
            if (qa.size() == 0) mon_err++;
            else a_data <= qa.pop_front();
        end
        if (b_rden === 1'b1) begin
            b_pops++;
            if (qb.size() == 0) mon_err++;
            else b_data <= qb.pop_front();
        end
        a_empty <= (qa.size() == 0);
        b_empty <= (qb.size() == 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_a(input logic [15:0] v);
        qa.push_back(v);
        a_empty = 1'b0;
    endtask

    task automatic push_b(input logic [15:0] v);
        qb.push_back(v);
        b_empty = 1'b0;
    endtask

    task automatic flush();
        qa.delete();
        qb.delete();
        a_empty = 1'b1;
        b_empty = 1'b1;
    endtask

    task automatic start_job(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        @(negedge clk);
        start = 1'b0;
        len   = 8'd0;
    endtask

    // Samples at negedges until result_valid; cyc is the index of the valid cycle.
    task automatic wait_valid(output int cyc, output int pops, output int last_pop, output bit to);
        cyc = 0; pops = 0; last_pop = -1; to = 1'b0;
        while (result_valid !== 1'b1) begin
            if (cyc >= 60) begin
                to = 1'b1;
                break;
            end
            if (a_rden === 1'b1) begin
                pops++;
                last_pop = cyc;
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = 8'd0; result_ready = 1'b0;
        a_empty = 1'b1; b_empty = 1'b1; a_data = '0; b_data = '0;
        mon_err = 0; a_pops = 0; b_pops = 0;
        #3;
        tests++;
        if ({a_rden, b_rden, result_valid, busy, overflow} !== 5'b0 || result !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: got rden=%b/%b valid=%b busy=%b ovf=%b result=%0d expected all 0",
                     a_rden, b_rden, result_valid, busy, overflow, result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc, pops, last_pop;
        bit to;
        push_a(16'd3); push_b(16'd4);
        start_job(8'd1);
        wait_valid(cyc, pops, last_pop, to);
        tests++;
        if (to || result !== 32'd12) begin
            fails++;
            $display("FAIL single_result: got %0d (timeout=%0d) expected 12", result, to);
        end
        tests++;
        if (pops !== 1 || cyc !== 2 || last_pop !== 0) begin
            fails++;
            $display("FAIL single_latency: got pops=%0d valid_cycle=%0d pop_cycle=%0d expected 1/2/0",
                     pops, cyc, last_pop);
        end
        tests++;
        if (overflow !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_flags: got ovf=%b busy=%b expected 0/1", overflow, busy);
        end
        accept();
        tests++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_accept: got busy=%b valid=%b expected 0/0", busy, result_valid);
        end
    endtask

    task automatic test_streaming();
        int cyc, pops, last_pop;
        bit to;
        for (int i = 0; i < 4; i++) begin
            push_a(16'(i + 1));
            push_b(16'(i + 5));
        end
        start_job(8'd4);
        wait_valid(cyc, pops, last_pop, to);
        tests++;
        if (to || result !== 32'd70) begin
            fails++;
            $display("FAIL stream_result: got %0d (timeout=%0d) expected 70", result, to);
        end
        tests++;
        if (pops !== 4 || last_pop !== 3 || cyc !== 5) begin
            fails++;
            $display("FAIL stream_timing: got pops=%0d last_pop=%0d valid_cycle=%0d expected 4/3/5",
                     pops, last_pop, cyc);
        end
        accept();
    endtask

    task automatic test_empty_stall();
        int cyc, viol, pops_early;
        a_pops = 0; b_pops = 0;
        push_a(16'd1); push_a(16'd2); push_a(16'd3);
        push_b(16'd4);
        start_job(8'd3);
        cyc = 0; viol = 0; pops_early = -1;
        while (result_valid !== 1'b1 && cyc < 60) begin
            if (b_empty && (a_rden || b_rden)) viol++;
            if (cyc == 3) begin
                pops_early = a_pops;
                push_b(16'd5);
                push_b(16'd6);
            end
            cyc++;
            @(negedge clk);
        end
        tests++;
        if (viol !== 0 || pops_early !== 1) begin
            fails++;
            $display("FAIL stall_no_pop: got violations=%0d pops_before_refill=%0d expected 0/1",
                     viol, pops_early);
        end
        tests++;
        if (a_pops !== 3 || b_pops !== 3) begin
            fails++;
            $display("FAIL stall_pop_count: got a=%0d b=%0d expected 3/3", a_pops, b_pops);
        end
        tests++;
        if (result_valid !== 1'b1 || result !== 32'd32) begin
            fails++;
            $display("FAIL stall_result: got %0d valid=%b expected 32/1", result, result_valid);
        end
        accept();
    endtask

    task automatic test_overflow();
        int cyc, pops, last_pop;
        bit to;
        push_a(16'hFFFF); push_a(16'hFFFF);
        push_b(16'hFFFF); push_b(16'hFFFF);
        start_job(8'd2);
        wait_valid(cyc, pops, last_pop, to);
        tests++;
        if (to || result !== 32'hFFFC0002 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_wrap: got %h ovf=%b (timeout=%0d) expected fffc0002/1", result, overflow, to);
        end
        accept();
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: got ovf=%b after accept expected 1", overflow);
        end
        push_a(16'd2); push_b(16'd3);
        start_job(8'd1);
        wait_valid(cyc, pops, last_pop, to);
        tests++;
        if (to || result !== 32'd6 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_cleared: got %0d ovf=%b (timeout=%0d) expected 6/0", result, overflow, to);
        end
        accept();
    endtask

    task automatic test_zero_backpressure();
        int cyc, pops, last_pop;
        bit to;
        push_a(16'd7); push_b(16'd7);
        start_job(8'd0);
        wait_valid(cyc, pops, last_pop, to);
        tests++;
        if (to || cyc !== 0 || pops !== 0 || result !== 32'd0) begin
            fails++;
            $display("FAIL zero_len: got valid_cycle=%0d pops=%0d result=%0d expected 0/0/0",
                     cyc, pops, result);
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (result_valid !== 1'b1 || busy !== 1'b1 || result !== 32'd0 || a_rden !== 1'b0) begin
                fails++;
                $display("FAIL hold_%0d: got valid=%b busy=%b result=%0d rden=%b expected 1/1/0/0",
                         i, result_valid, busy, result, a_rden);
            end
            start = 1'b1;
            len   = 8'd5;
            @(negedge clk);
        end
        start = 1'b0;
        len   = 8'd0;
        accept();
        tests++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL release_idle: got busy=%b valid=%b expected 0/0", busy, result_valid);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || a_rden !== 1'b0) begin
            fails++;
            $display("FAIL ignored_start: got busy=%b rden=%b expected 0/0", busy, a_rden);
        end
        flush();
    endtask

    task automatic test_reset_mid_run();
        int cyc, pops, last_pop;
        bit to;
        for (int i = 0; i < 4; i++) begin
            push_a(16'(i + 1));
            push_b(16'(i + 1));
        end
        a_pops = 0;
        start_job(8'd4);
        repeat (2) @(negedge clk);
        tests++;
        if (a_pops !== 2 || a_rden !== 1'b1) begin
            fails++;
            $display("FAIL midrun_progress: got pops=%0d rden=%b expected 2/1", a_pops, a_rden);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (a_rden !== 1'b0 || b_rden !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midrun_async: got rden=%b/%b valid=%b busy=%b expected 0/0/0/0",
                     a_rden, b_rden, result_valid, busy);
        end
        @(negedge clk);
        flush();
        rst_n = 1'b1;
        @(negedge clk);
        push_a(16'd2); push_b(16'd9);
        start_job(8'd1);
        wait_valid(cyc, pops, last_pop, to);
        tests++;
        if (to || result !== 32'd18 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL fresh_after_reset: got %0d ovf=%b (timeout=%0d) expected 18/0", result, overflow, to);
        end
        accept();
    endtask

    task automatic test_protocol();
        tests++;
        if (mon_err !== 0) begin
            fails++;
            $display("FAIL fifo_protocol: got %0d violations expected 0", mon_err);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_streaming();
        test_empty_stall();
        test_overflow();
        test_zero_backpressure();
        test_reset_mid_run();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
